svd_dp_seq: RTL

SVD_DP_SEQ -- requirements
Module: svd_dp_seq

---
 rtl/svd_dp_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/svd_dp_seq.sv
// Sequencer for the SVD datapath: loads operands, runs a fixed-length CORDIC rotation window,
// writes results back to the A/U/V DRAMs and serves single-cycle readouts.
module svd_dp_seq #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned LANES = 16,
  parameter int unsigned ITER  = 16,
  parameter int unsigned CW    = 5,
  localparam int unsigned DW   = LANES * WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [1:0]    slot_en,
  input  logic [2:0]    sel_rot,
  input  logic          rd_en,
  input  logic [DW-1:0] data_in,
  input  logic [DW-1:0] dram_out_A,
  input  logic [DW-1:0] dram_out_U,
  input  logic [DW-1:0] dram_out_V,
  input  logic [DW-1:0] cordic_res_A,
  input  logic [DW-1:0] cordic_res_UV,
  output logic [DW-1:0] cordic_op_A,
  output logic [DW-1:0] cordic_op_UV,
  output logic          ce0_A,
  output logic          ce1_A,
  output logic          ce0_UV,
  output logic          ce1_UV,
  output logic [2:0]    idx_rot,
  output logic [DW-1:0] dram_in_A,
  output logic [DW-1:0] dram_in_U,
  output logic [DW-1:0] dram_in_V,
  output logic          we_A,
  output logic          we_U,
  output logic          we_V,
  output logic [DW-1:0] data_out_svd_A,
  output logic [DW-1:0] data_out_svd_U,
  output logic [DW-1:0] data_out_svd_V,
  output logic          out_valid,
  output logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {StIdle, StRot, StWb} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    mode_q;
  logic [1:0]    slot_q;
  logic          accept;
  logic          rd_accept;
  logic          rot;
  logic          wb;

  assign accept    = (state_q == StIdle) && start && !abort;
  assign rd_accept = (state_q == StIdle) && rd_en && !start && !abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (mode == 2'd0) ? StWb : StRot;
          cnt_d   = (mode == 2'd0) ? '0 : CW'(1);
        end
      end
      StRot: begin
        if (cnt_q == CW'(ITER)) begin
          state_d = StWb;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StWb: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mode 0 parks data_in in cordic_op_A so the write-back has a registered source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= '0;
      slot_q       <= '0;
      idx_rot      <= '0;
      cordic_op_A  <= '0;
      cordic_op_UV <= '0;
    end else if (accept) begin
      mode_q  <= mode;
      slot_q  <= slot_en;
      idx_rot <= sel_rot;
      unique case (mode)
        2'd0:    cordic_op_A  <= data_in;
        2'd1:    cordic_op_A  <= dram_out_A;
        2'd2:    cordic_op_UV <= dram_out_U;
        default: cordic_op_UV <= dram_out_V;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      data_out_svd_A <= '0;
      data_out_svd_U <= '0;
      data_out_svd_V <= '0;
    end else begin
      out_valid <= rd_accept;
      if (rd_accept) begin
        data_out_svd_A <= dram_out_A;
        data_out_svd_U <= dram_out_U;
        data_out_svd_V <= dram_out_V;
      end
    end
  end

  assign rot  = (state_q == StRot);
  // An abort landing on the write-back cycle suppresses the write.
  assign wb   = (state_q == StWb) && !abort;
  assign busy = (state_q != StIdle);
  assign cnt  = cnt_q;

  assign ce0_A  = rot && (mode_q == 2'd1) && slot_q[0];
  assign ce1_A  = rot && (mode_q == 2'd1) && slot_q[1];
  assign ce0_UV = rot && (mode_q[1]) && slot_q[0];
  assign ce1_UV = rot && (mode_q[1]) && slot_q[1];

  assign we_A = wb && !mode_q[1];
  assign we_U = wb && (mode_q == 2'd2);
  assign we_V = wb && (mode_q == 2'd3);
  assign done = wb;

  always_comb begin
    dram_in_A = '0;
    dram_in_U = '0;
    dram_in_V = '0;
    if (we_A) dram_in_A = (mode_q == 2'd0) ? cordic_op_A : cordic_res_A;
    if (we_U) dram_in_U = cordic_res_UV;
    if (we_V) dram_in_V = cordic_res_UV;
  end

endmodule
